vga_text_render: RTL and testbench

- Pipelined text-mode pixel renderer, one pixel per clock.
- Maps a pixel coordinate to a character cell, reads text RAM, then reads font RAM, and outputs an RGB332 colour.
- Colours come from the character attribute byte; the block also handles attribute blink, a blinking hardware cursor and 9-pixel-wide cells.
- Sits between the VGA timing generator (coordinate and frame source) and the DAC/output register stage.

---
 rtl/vga_text_render.sv | 144 ++++++++++++++
 tb/tb_vga_text_render.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_render.sv
// Text-mode pixel renderer: pixel coordinate -> text RAM -> font RAM -> RGB332.
// Fixed 4-cycle latency, one pixel per clock, with attribute blink, hardware cursor and 9-pixel cells.
module vga_text_render #(
    parameter int COLS         = 80,
    parameter int ROWS         = 25,
    parameter int FONT_W       = 8,
    parameter int FONT_H       = 14,
    parameter int BLINK_FRAMES = 16,
    parameter int CURSOR_START = 12,
    parameter int CURSOR_END   = 13
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        px_valid,
    input  logic [9:0]  px_x,
    input  logic [9:0]  px_y,
    input  logic        frame_start,
    input  logic        cursor_en,
    input  logic [10:0] cursor_pos,
    output logic [10:0] text_a,
    input  logic [15:0] text_dr,
    output logic [12:0] font_a,
    input  logic [7:0]  font_dr,
    output logic [7:0]  p,
    output logic        p_valid
);

    localparam logic [9:0] FW = 10'(FONT_W);
    localparam logic [9:0] FH = 10'(FONT_H);
    localparam int         CW = $clog2(BLINK_FRAMES + 1);

    typedef struct packed {
        logic       valid;
        logic       in_range;
        logic       hit;
        logic       blink;
        logic [3:0] xoff;
    } meta_t;

    logic [9:0]  col, row;
    logic [3:0]  xoff;
    logic [4:0]  yoff;
    logic [10:0] cell_idx;
    logic        in_range, cursor_hit;

    meta_t       s1, s2, s3, s4;
    logic [4:0]  yoff1, yoff2;
    logic [15:0] word3, word4;

    logic [CW-1:0] frame_cnt;
    logic          blink_phase;

    logic        glyph_bit, pix_on;
    logic [3:0]  fg_idx, bg_idx;
    logic [7:0]  pix_rgb;

    function automatic logic [7:0] pal(input logic [3:0] c);
        logic [2:0] r, g;
        logic [1:0] b;
        r = c[2] ? (c[3] ? 3'b111 : 3'b101) : (c[3] ? 3'b010 : 3'b000);
        g = c[1] ? (c[3] ? 3'b111 : 3'b101) : (c[3] ? 3'b010 : 3'b000);
        b = c[0] ? (c[3] ? 2'b11 : 2'b10) : (c[3] ? 2'b01 : 2'b00);
        return {r, g, b};
    endfunction

    // The 11-bit cell index may wrap for off-screen coordinates; in_range masks that case.
    always_comb begin
        col        = px_x / FW;
        row        = px_y / FH;
        xoff       = 4'(px_x % FW);
        yoff       = 5'(px_y % FH);
        in_range   = ({1'b0, col} < 11'(COLS)) && ({1'b0, row} < 11'(ROWS));
        cell_idx   = {1'b0, row} * 11'(COLS) + {1'b0, col};
        cursor_hit = cursor_en && in_range && (cell_idx == cursor_pos) &&
                     (yoff >= 5'(CURSOR_START)) && (yoff <= 5'(CURSOR_END));
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + CW'(1);
            end
        end
    end

    // Metadata rides alongside the two RAM reads so it meets the matching data at each stage.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            text_a  <= '0;
            font_a  <= '0;
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            s4      <= '0;
            yoff1   <= '0;
            yoff2   <= '0;
            word3   <= '0;
            word4   <= '0;
            p       <= 8'h00;
            p_valid <= 1'b0;
        end else begin
            text_a      <= (px_valid && in_range) ? cell_idx : 11'd0;
            s1.valid    <= px_valid;
            s1.in_range <= in_range;
            s1.hit      <= cursor_hit;
            s1.blink    <= blink_phase;
            s1.xoff     <= xoff;
            yoff1       <= yoff;

            s2    <= s1;
            yoff2 <= yoff1;

            s3     <= s2;
            word3  <= text_dr;
            font_a <= {5'b0, text_dr[7:0]} * 13'(FONT_H) + {8'b0, yoff2};

            s4    <= s3;
            word4 <= word3;

            p_valid <= s4.valid;
            p       <= (s4.valid && s4.in_range) ? pix_rgb : 8'h00;
        end
    end

    // Column 8 of a 9-wide cell repeats column 7 only for the line-drawing codes 0xC0-0xDF.
    always_comb begin
        glyph_bit = 1'b0;
        if (s4.xoff < 4'd8)
            glyph_bit = font_dr[s4.xoff[2:0]];
        else if (FONT_W == 9 && word4[7:5] == 3'b110)
            glyph_bit = font_dr[7];
        bg_idx  = {1'b0, word4[14:12]};
        fg_idx  = (word4[15] && s4.blink) ? bg_idx : word4[11:8];
        pix_on  = (s4.hit && !s4.blink) || glyph_bit;
        pix_rgb = pal(pix_on ? fg_idx : bg_idx);
    end

endmodule

// File: tb/tb_vga_text_render.sv
// Self-checking bench for vga_text_render (9-pixel cells, 2-frame blink) with
// behavioural synchronous-read text and font RAMs.
module tb_vga_text_render;

    localparam int FW   = 9;
    localparam int FH   = 14;
    localparam int CPOS = 81;

    typedef struct {
        logic       v;
        logic       fs;
        logic       ce;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] ep;
        logic       ev;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        px_valid, frame_start, cursor_en;
    logic [9:0]  px_x, px_y;
    logic [10:0] cursor_pos;
    logic [10:0] text_a;
    logic [15:0] text_dr = 16'h0;
    logic [12:0] font_a;
    logic [7:0]  font_dr = 8'h0;
    logic [7:0]  p;
    logic        p_valid;

    logic [15:0] text_mem [0:2047];
    logic [7:0]  font_mem [0:8191];

    vec_t tbl [0:1023];
    int   tbl_n = 0;
    int   pass_cnt = 0;
    int   check_cnt = 0;

    vga_text_render #(
        .COLS(80), .ROWS(25), .FONT_W(FW), .FONT_H(FH),
        .BLINK_FRAMES(2), .CURSOR_START(12), .CURSOR_END(13)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
        .frame_start(frame_start), .cursor_en(cursor_en), .cursor_pos(cursor_pos),
        .text_a(text_a), .text_dr(text_dr),
        .font_a(font_a), .font_dr(font_dr),
        .p(p), .p_valid(p_valid)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        text_dr <= text_mem[text_a];
        font_dr <= font_mem[font_a];
    end

    function automatic logic [7:0] pal_ref(input logic [3:0] c);
        logic [2:0] r, g;
        logic [1:0] b;
        case ({c[2], c[3]})
            2'b00: r = 3'd0;
            2'b01: r = 3'd2;
            2'b10: r = 3'd5;
            default: r = 3'd7;
        endcase
        case ({c[1], c[3]})
            2'b00: g = 3'd0;
            2'b01: g = 3'd2;
            2'b10: g = 3'd5;
            default: g = 3'd7;
        endcase
        b = {c[0], c[3]};
        return {r, g, b};
    endfunction

    function automatic logic [7:0] model_pixel(input int x, input int y, input bit bp, input bit ce);
        int          col, xo, row, yo, idx;
        logic [15:0] w;
        logic [7:0]  f;
        logic [3:0]  fgc, bgc;
        bit          g, hit, on;
        col = x / FW;
        xo  = x % FW;
        row = y / FH;
        yo  = y % FH;
        if (col >= 80 || row >= 25) return 8'h00;
        idx = row * 80 + col;
        w   = text_mem[idx];
        f   = font_mem[int'(w[7:0]) * FH + yo];
        if (xo < 8) g = f[xo];
        else        g = (w[7:0] >= 8'hC0 && w[7:0] <= 8'hDF) ? f[7] : 1'b0;
        hit = ce && idx == CPOS && yo >= 12 && yo <= 13;
        bgc = {1'b0, w[14:12]};
        fgc = (w[15] && bp) ? bgc : w[11:8];
        on  = (hit && !bp) ? 1'b1 : g;
        return on ? pal_ref(fgc) : pal_ref(bgc);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic fs, input logic ce, input logic [9:0] x, input logic [9:0] y);
        px_valid    = v;
        frame_start = fs;
        cursor_en   = ce;
        px_x        = x;
        px_y        = y;
    endtask

    task automatic addVec(input logic v, input logic fs, input logic ce, input int x, input int y,
                          input logic [7:0] ep, input logic ev);
        tbl[tbl_n].v  = v;
        tbl[tbl_n].fs = fs;
        tbl[tbl_n].ce = ce;
        tbl[tbl_n].x  = 10'(x);
        tbl[tbl_n].y  = 10'(y);
        tbl[tbl_n].ep = ep;
        tbl[tbl_n].ev = ev;
        tbl_n++;
    endtask

    task automatic addIdle(input logic fs);
        addVec(1'b0, fs, 1'b0, 0, 0, 8'h00, 1'b0);
    endtask

    // One vector enters per edge; its result is sampled 1 ns after the fourth following edge.
    task automatic runTable(input string tag);
        for (int t = 0; t < tbl_n + 4; t++) begin
            if (t < tbl_n) applyStimulus(tbl[t].v, tbl[t].fs, tbl[t].ce, tbl[t].x, tbl[t].y);
            else           applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
            @(posedge sys_clk);
            #1;
            if (t >= 4) begin
                checkOutput($sformatf("%s[%0d].p", tag, t - 4), {8'h0, p}, {8'h0, tbl[t - 4].ep});
                checkOutput($sformatf("%s[%0d].p_valid", tag, t - 4), {15'h0, p_valid}, {15'h0, tbl[t - 4].ev});
            end
        end
        tbl_n = 0;
    endtask

    initial begin
        sys_rst    = 1'b1;
        cursor_pos = 11'(CPOS);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);

        for (int i = 0; i < 2048; i++) text_mem[i] = 16'h0000;
        for (int i = 0; i < 8192; i++) font_mem[i] = 8'(i * 37 + 11);
        for (int c = 9; c < 80; c++) text_mem[c] = 16'((c * 16'h9E37) ^ 16'h5A5A);
        text_mem[0]    = 16'h1E41;
        text_mem[1]    = 16'h1EC4;
        text_mem[2]    = 16'h1E41;
        text_mem[3]    = 16'h4A41;
        text_mem[4]    = 16'h9E41;
        text_mem[5]    = 16'h1EDF;
        text_mem[6]    = 16'h1EE0;
        text_mem[7]    = 16'h1EC0;
        text_mem[8]    = 16'h1EBF;
        text_mem[80]   = 16'h7F41;
        text_mem[81]   = 16'h1E00;
        text_mem[1999] = 16'h1E41;
        font_mem[915]  = 8'h88;
        font_mem[2749] = 8'h80;
        font_mem[3127] = 8'h80;
        font_mem[3141] = 8'h80;
        font_mem[2693] = 8'h80;
        font_mem[2679] = 8'h80;
        font_mem[11]   = 8'h00;
        font_mem[12]   = 8'h00;
        font_mem[13]   = 8'h00;

        repeat (2) @(posedge sys_clk);
        #1;
        checkOutput("reset.p", {8'h0, p}, 16'h0000);
        checkOutput("reset.p_valid", {15'h0, p_valid}, 16'h0000);
        checkOutput("reset.text_a", {5'h0, text_a}, 16'h0000);
        checkOutput("reset.font_a", {3'h0, font_a}, 16'h0000);
        sys_rst = 1'b0;

        // Colours, glyph columns, 9th-column rule and off-screen coordinates.
        addVec(1, 0, 0,    3,    5, 8'hFD, 1);
        addVec(1, 0, 0,    2,    5, 8'h02, 1);
        addIdle(1'b0);
        addVec(1, 0, 0,   17,    5, 8'hFD, 1);
        addVec(1, 0, 0,   26,    5, 8'h02, 1);
        addVec(1, 0, 0,    8,    5, 8'h02, 1);
        addVec(1, 0, 0,   53,    5, 8'hFD, 1);
        addVec(1, 0, 0,   62,    5, 8'h02, 1);
        addVec(1, 0, 0,   71,    5, 8'hFD, 1);
        addVec(1, 0, 0,   80,    5, 8'h02, 1);
        addVec(1, 0, 0,   30,    5, 8'h5D, 1);
        addVec(1, 0, 0,   28,    5, 8'hA0, 1);
        addVec(1, 0, 0,    3,   19, 8'hFF, 1);
        addVec(1, 0, 0,    4,   19, 8'hB6, 1);
        addVec(1, 0, 0,  714,  341, 8'hFD, 1);
        addVec(1, 0, 0,  720,    5, 8'h00, 1);
        addVec(1, 0, 0,    0,  350, 8'h00, 1);
        addVec(1, 0, 0, 1023, 1023, 8'h00, 1);
        runTable("directed");

        applyStimulus(1'b1, 1'b0, 1'b0, 10'd714, 10'd341);
        @(posedge sys_clk);
        #1;
        checkOutput("addr.text_a_last_cell", {5'h0, text_a}, 16'd1999);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd720, 10'd5);
        @(posedge sys_clk);
        #1;
        checkOutput("addr.text_a_offscreen", {5'h0, text_a}, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        @(posedge sys_clk);
        #1;
        checkOutput("addr.font_a", {3'h0, font_a}, 16'd915);
        repeat (4) @(posedge sys_clk);
        #1;

        // Scanline stream with periodic 5-cycle gaps, expectations from the reference model.
        for (int x = 0; x < 640; x++) begin
            if (x > 0 && x % 128 == 0)
                for (int g = 0; g < 5; g++) addIdle(1'b0);
            addVec(1, 0, 0, x, 0, model_pixel(x, 0, 1'b0, 1'b0), 1);
        end
        runTable("stream");

        // Attribute blink; a frame_start coinciding with a request uses the old phase.
        addVec(1, 0, 0, 39, 5, 8'hFD, 1);
        addIdle(1'b1);
        addIdle(1'b0);
        addVec(1, 1, 0, 39, 5, 8'hFD, 1);
        addVec(1, 0, 0, 39, 5, 8'h02, 1);
        addVec(1, 0, 0, 40, 5, 8'h02, 1);
        addIdle(1'b1);
        addVec(1, 0, 0, 39, 5, 8'h02, 1);
        addIdle(1'b1);
        addVec(1, 0, 0, 39, 5, 8'hFD, 1);
        runTable("blink");

        // Cursor over cell 81 on scanlines 12-13, then hidden during the off phase.
        for (int x = 9; x <= 17; x++) addVec(1, 0, 1, x, 26, 8'hFD, 1);
        addVec(1, 0, 1,  9, 25, 8'h02, 1);
        addVec(1, 0, 1,  9, 27, 8'hFD, 1);
        addVec(1, 0, 0,  9, 26, 8'h02, 1);
        addIdle(1'b1);
        addIdle(1'b1);
        addVec(1, 0, 1,  9, 26, 8'h02, 1);
        addVec(1, 0, 1, 13, 27, 8'h02, 1);
        runTable("cursor");

        // Asynchronous reset with the pipeline full, then a clean restart.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 10'd714, 10'd341);
            @(posedge sys_clk);
            #1;
        end
        checkOutput("midreset.pre_p", {8'h0, p}, 16'h00FD);
        checkOutput("midreset.pre_p_valid", {15'h0, p_valid}, 16'h0001);
        #2;
        sys_rst = 1'b1;
        #1;
        checkOutput("midreset.p", {8'h0, p}, 16'h0000);
        checkOutput("midreset.p_valid", {15'h0, p_valid}, 16'h0000);
        checkOutput("midreset.text_a", {5'h0, text_a}, 16'h0000);
        checkOutput("midreset.font_a", {3'h0, font_a}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge sys_clk);
            #1;
            checkOutput($sformatf("postreset.p_valid[%0d]", i), {15'h0, p_valid}, 16'h0000);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd3, 10'd5);
        @(posedge sys_clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("restart.p_valid_n3", {15'h0, p_valid}, 16'h0000);
        @(posedge sys_clk);
        #1;
        checkOutput("restart.p_valid_n4", {15'h0, p_valid}, 16'h0001);
        checkOutput("restart.p_n4", {8'h0, p}, 16'h00FD);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
